// File: rtl/text_buffer_pkg.sv
// Shared sizes, command opcodes and controller states for the text buffer writer.
package text_buffer_pkg;

   localparam int DEF_COLS   = 10;
   localparam int DEF_ROWS   = 2;
   localparam int DEF_CODE_W = 6;

   // Command port index widths are fixed by the software-facing interface.
   localparam int COL_W = 4;
   localparam int ROW_W = 1;

   typedef enum logic [1:0] {
      OP_PUT    = 2'b00,
      OP_MOVE   = 2'b01,
      OP_CLEAR  = 2'b10,
      OP_COMMIT = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE       = 2'b00,
      S_CLEAR      = 2'b01,
      S_WAIT_FRAME = 2'b10
   } state_e;

endpackage

// File: rtl/text_buffer_writer_cell_cursor.sv
// Column/row position counter with load, advance-with-wrap and a last-cell flag.
module cell_cursor #(
   parameter int COLS  = 10,
   parameter int ROWS  = 2,
   parameter int COL_W = 4,
   parameter int ROW_W = 1
) (
   input  logic             clk50,
   input  logic             reset,
   input  logic             load,
   input  logic [COL_W-1:0] load_col,
   input  logic [ROW_W-1:0] load_row,
   input  logic             advance,
   output logic [COL_W-1:0] col,
   output logic [ROW_W-1:0] row,
   output logic             last
);

   localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

   always_ff @(posedge clk50) begin
      if (reset) begin
         col <= '0;
         row <= '0;
      end else if (load) begin
         col <= load_col;
         row <= load_row;
      end else if (advance) begin
         if (col == COL_MAX) begin
            col <= '0;
            row <= (row == ROW_MAX) ? '0 : row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

   assign last = (col == COL_MAX) && (row == ROW_MAX);

endmodule

// File: rtl/text_buffer_writer.sv
// Command-driven back buffer editor with a frame-synchronous copy to the displayed front buffer.
//
//   state        | meaning
//   S_IDLE       | accepting PUT/MOVE/CLEAR/COMMIT, one per cycle
//   S_CLEAR      | zeroing one back-buffer cell per cycle in row-major order
//   S_WAIT_FRAME | commit requested, back buffer frozen until frame_start
module text_buffer_writer
   import text_buffer_pkg::*;
#(
   parameter int COLS   = DEF_COLS,
   parameter int ROWS   = DEF_ROWS,
   parameter int CODE_W = DEF_CODE_W
) (
   input  logic                                  clk50,
   input  logic                                  reset,
   input  logic                                  cmd_valid,
   output logic                                  cmd_ready,
   input  logic [1:0]                            cmd_op,
   input  logic [CODE_W-1:0]                     cmd_data,
   input  logic [COL_W-1:0]                      cmd_col,
   input  logic [ROW_W-1:0]                      cmd_row,
   input  logic                                  frame_start,
   output logic [COLS-1:0][ROWS-1:0][CODE_W-1:0] frame_buffer,
   output logic [COL_W-1:0]                      cursor_col,
   output logic [ROW_W-1:0]                      cursor_row,
   output logic                                  commit_pending
);

   localparam logic [COL_W-1:0] COL_LIMIT = COL_W'(COLS);

   state_e                               state;
   logic [COLS-1:0][ROWS-1:0][CODE_W-1:0] back;

   op_e              op;
   logic             accept;
   logic             sweep_done;
   logic             cur_load;
   logic [COL_W-1:0] cur_load_col;
   logic [ROW_W-1:0] cur_load_row;
   logic             cur_advance;
   logic             cur_last_unused;
   logic             sw_load;
   logic             sw_advance;
   logic [COL_W-1:0] sw_col;
   logic [ROW_W-1:0] sw_row;
   logic             sw_last;

   assign op          = op_e'(cmd_op);
   assign accept      = cmd_valid && (state == S_IDLE);
   assign sweep_done  = (state == S_CLEAR) && sw_last;

   // Out-of-range MOVE targets are consumed but leave the cursor alone.
   assign cur_load     = (accept && (op == OP_MOVE) && (cmd_col < COL_LIMIT)) || sweep_done;
   assign cur_load_col = sweep_done ? '0 : cmd_col;
   assign cur_load_row = sweep_done ? '0 : cmd_row;
   assign cur_advance  = accept && (op == OP_PUT);

   assign sw_load    = accept && (op == OP_CLEAR);
   assign sw_advance = (state == S_CLEAR);

   cell_cursor #(
      .COLS  (COLS),
      .ROWS  (ROWS),
      .COL_W (COL_W),
      .ROW_W (ROW_W)
   ) u_write_cursor (
      .clk50    (clk50),
      .reset    (reset),
      .load     (cur_load),
      .load_col (cur_load_col),
      .load_row (cur_load_row),
      .advance  (cur_advance),
      .col      (cursor_col),
      .row      (cursor_row),
      .last     (cur_last_unused)
   );

   cell_cursor #(
      .COLS  (COLS),
      .ROWS  (ROWS),
      .COL_W (COL_W),
      .ROW_W (ROW_W)
   ) u_sweep_index (
      .clk50    (clk50),
      .reset    (reset),
      .load     (sw_load),
      .load_col ('0),
      .load_row ('0),
      .advance  (sw_advance),
      .col      (sw_col),
      .row      (sw_row),
      .last     (sw_last)
   );

   always_ff @(posedge clk50) begin
      if (reset) begin
         state        <= S_IDLE;
         back         <= '0;
         frame_buffer <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  unique case (op)
                     OP_PUT:    back[cursor_col][cursor_row] <= cmd_data;
                     OP_CLEAR:  state <= S_CLEAR;
                     OP_COMMIT: state <= S_WAIT_FRAME;
                     default:   ;
                  endcase
               end
            end
            S_CLEAR: begin
               back[sw_col][sw_row] <= '0;
               if (sw_last) state <= S_IDLE;
            end
            S_WAIT_FRAME: begin
               if (frame_start) begin
                  frame_buffer <= back;
                  state        <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready      = (state == S_IDLE);
   assign commit_pending = (state == S_WAIT_FRAME);

endmodule

// File: tb/tb_text_buffer_writer.sv
// Directed bench for text_buffer_writer with a per-cycle cell-array model and literal spot checks.
module tb_text_buffer_writer;
   import text_buffer_pkg::*;

   localparam int NC    = 10;
   localparam int NR    = 2;
   localparam int NCELL = NC * NR;

   logic       clk50       = 1'b0;
   logic       reset       = 1'b1;
   logic       cmd_valid   = 1'b0;
   logic [1:0] cmd_op      = 2'b00;
   logic [5:0] cmd_data    = '0;
   logic [3:0] cmd_col     = '0;
   logic       cmd_row     = 1'b0;
   logic       frame_start = 1'b0;
   logic       cmd_ready;
   logic       commit_pending;
   logic [3:0] cursor_col;
   logic       cursor_row;
   logic [NC-1:0][NR-1:0][5:0] frame_buffer;

   int n_checks = 0;
   int n_err    = 0;

   // Model: cells indexed linearly as row*NC+col, cursor as a linear position.
   int m_back  [NCELL];
   int m_front [NCELL];
   int m_pos;
   int m_clear_left;
   int m_clear_idx;
   bit m_pending;
   bit chk_en = 1'b0;

   text_buffer_writer dut (
      .clk50          (clk50),
      .reset          (reset),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_op         (cmd_op),
      .cmd_data       (cmd_data),
      .cmd_col        (cmd_col),
      .cmd_row        (cmd_row),
      .frame_start    (frame_start),
      .frame_buffer   (frame_buffer),
      .cursor_col     (cursor_col),
      .cursor_row     (cursor_row),
      .commit_pending (commit_pending)
   );

   always #10 clk50 = ~clk50;

   always @(posedge clk50) begin
      if (reset) begin
         for (int i = 0; i < NCELL; i++) begin
            m_back[i]  = 0;
            m_front[i] = 0;
         end
         m_pos        = 0;
         m_clear_left = 0;
         m_clear_idx  = 0;
         m_pending    = 1'b0;
         chk_en       = 1'b1;
      end else if (m_clear_left > 0) begin
         m_back[m_clear_idx] = 0;
         m_clear_idx++;
         m_clear_left--;
         if (m_clear_left == 0) m_pos = 0;
      end else if (m_pending) begin
         if (frame_start) begin
            m_front   = m_back;
            m_pending = 1'b0;
         end
      end else if (cmd_valid) begin
         case (cmd_op)
            2'b00: begin
               m_back[m_pos] = int'(cmd_data);
               m_pos = (m_pos + 1) % NCELL;
            end
            2'b01: if (int'(cmd_col) < NC) m_pos = int'(cmd_row) * NC + int'(cmd_col);
            2'b10: begin
               m_clear_left = NCELL;
               m_clear_idx  = 0;
            end
            default: m_pending = 1'b1;
         endcase
      end
   end

   always @(negedge clk50) begin : compare
      bit fb_ok;
      int bad;
      int exp_col;
      int exp_row;
      bit exp_ready;
      if (chk_en) begin
         fb_ok = 1'b1;
         bad   = -1;
         for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++)
               if (frame_buffer[c][r] !== 6'(m_front[r*NC+c])) begin
                  fb_ok = 1'b0;
                  if (bad < 0) bad = r*NC + c;
               end
         n_checks++;
         if (!fb_ok) begin
            n_err++;
            $display("FAIL model_frame_buffer t=%0t cell(%0d,%0d): got %0d expected %0d",
                     $time, bad % NC, bad / NC, frame_buffer[bad % NC][bad / NC], m_front[bad]);
         end
         exp_col   = m_pos % NC;
         exp_row   = m_pos / NC;
         exp_ready = !m_pending && (m_clear_left == 0);
         n_checks++;
         if (cursor_col !== 4'(exp_col) || cursor_row !== 1'(exp_row)) begin
            n_err++;
            $display("FAIL model_cursor t=%0t: got (%0d,%0d) expected (%0d,%0d)",
                     $time, cursor_col, cursor_row, exp_col, exp_row);
         end
         n_checks++;
         if (cmd_ready !== exp_ready) begin
            n_err++;
            $display("FAIL model_cmd_ready t=%0t: got %b expected %b", $time, cmd_ready, exp_ready);
         end
         n_checks++;
         if (commit_pending !== m_pending) begin
            n_err++;
            $display("FAIL model_commit_pending t=%0t: got %b expected %b",
                     $time, commit_pending, m_pending);
         end
      end
   end

   task automatic check_lit(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input bit v, input logic [1:0] op, input int data,
                       input int col, input int row, input bit fs);
      reset       = 1'b0;
      cmd_valid   = v;
      cmd_op      = op;
      cmd_data    = 6'(data);
      cmd_col     = 4'(col);
      cmd_row     = 1'(row);
      frame_start = fs;
      @(negedge clk50);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, OP_PUT, 0, 0, 0, 1'b0);
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      cmd_valid   = 1'b0;
      frame_start = 1'b0;
      @(negedge clk50);
      reset = 1'b0;
   endtask

   function automatic int fb_sum();
      int s = 0;
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < NR; r++) s += int'(frame_buffer[c][r]);
      return s;
   endfunction

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int n;
      @(negedge clk50);
      do_reset();
      check_lit("reset_fb", fb_sum(), 0);
      check_lit("reset_cursor_col", int'(cursor_col), 0);
      check_lit("reset_cursor_row", int'(cursor_row), 0);
      check_lit("reset_ready", int'(cmd_ready), 1);
      check_lit("reset_pending", int'(commit_pending), 0);

      // Ten PUTs, commit, frame_start 50 cycles later.
      for (int i = 1; i <= 10; i++) step(1'b1, OP_PUT, i, 0, 0, 1'b0);
      step(1'b1, OP_COMMIT, 0, 0, 0, 1'b0);
      idle(49);
      check_lit("t1_before_swap", int'(frame_buffer[9][0]), 0);
      check_lit("t1_pending", int'(commit_pending), 1);
      step(1'b0, OP_PUT, 0, 0, 0, 1'b1);
      check_lit("t1_cell0", int'(frame_buffer[0][0]), 1);
      check_lit("t1_cell9", int'(frame_buffer[9][0]), 10);
      check_lit("t1_row1", int'(frame_buffer[4][1]), 0);
      check_lit("t1_cursor_col", int'(cursor_col), 0);
      check_lit("t1_cursor_row", int'(cursor_row), 1);

      // Full wrap then one more PUT.
      step(1'b1, OP_MOVE, 0, 0, 0, 1'b0);
      for (int i = 0; i < NCELL; i++) step(1'b1, OP_PUT, 20 + i, 0, 0, 1'b0);
      step(1'b1, OP_PUT, 6, 0, 0, 1'b0);
      step(1'b1, OP_COMMIT, 0, 0, 0, 1'b0);
      idle(3);
      step(1'b0, OP_PUT, 0, 0, 0, 1'b1);
      check_lit("t2_cell00", int'(frame_buffer[0][0]), 6);
      check_lit("t2_cell10", int'(frame_buffer[1][0]), 21);
      check_lit("t2_cell91", int'(frame_buffer[9][1]), 39);
      check_lit("t2_cursor_col", int'(cursor_col), 1);
      check_lit("t2_cursor_row", int'(cursor_row), 0);

      // MOVE in range, PUT, MOVE out of range.
      step(1'b1, OP_MOVE, 0, 3, 1, 1'b0);
      step(1'b1, OP_PUT, 4, 0, 0, 1'b0);
      check_lit("t3_cursor_col", int'(cursor_col), 4);
      check_lit("t3_cursor_row", int'(cursor_row), 1);
      step(1'b1, OP_MOVE, 0, 12, 0, 1'b0);
      check_lit("t3_bad_move_col", int'(cursor_col), 4);
      check_lit("t3_bad_move_row", int'(cursor_row), 1);
      check_lit("t3_ready", int'(cmd_ready), 1);
      step(1'b1, OP_COMMIT, 0, 0, 0, 1'b0);
      step(1'b0, OP_PUT, 0, 0, 0, 1'b1);
      check_lit("t3_cell31", int'(frame_buffer[3][1]), 4);

      // Fill, commit, CLEAR, then commit the cleared buffer.
      step(1'b1, OP_MOVE, 0, 0, 0, 1'b0);
      for (int i = 0; i < NCELL; i++) step(1'b1, OP_PUT, i + 1, 0, 0, 1'b0);
      step(1'b1, OP_COMMIT, 0, 0, 0, 1'b0);
      step(1'b0, OP_PUT, 0, 0, 0, 1'b1);
      check_lit("t4_full", int'(frame_buffer[9][1]), 20);
      step(1'b1, OP_CLEAR, 0, 0, 0, 1'b0);
      n = 0;
      while (!cmd_ready && n < 100) begin
         n++;
         step(1'b0, OP_PUT, 0, 0, 0, 1'b1);
      end
      check_lit("t4_clear_busy_cycles", n, 20);
      check_lit("t4_front_kept", int'(frame_buffer[5][1]), 16);
      check_lit("t4_cursor_col", int'(cursor_col), 0);
      step(1'b1, OP_COMMIT, 0, 0, 0, 1'b0);
      step(1'b0, OP_PUT, 0, 0, 0, 1'b1);
      check_lit("t4_cleared_fb", fb_sum(), 0);

      // COMMIT coincident with frame_start must not swap.
      step(1'b1, OP_PUT, 7, 0, 0, 1'b0);
      step(1'b1, OP_COMMIT, 0, 0, 0, 1'b1);
      check_lit("t5_no_swap", int'(frame_buffer[0][0]), 0);
      check_lit("t5_pending", int'(commit_pending), 1);
      check_lit("t5_ready_low", int'(cmd_ready), 0);
      for (int i = 0; i < 5; i++) step(1'b1, OP_PUT, 9, 0, 0, 1'b0);
      check_lit("t5_still_pending", int'(commit_pending), 1);
      step(1'b1, OP_PUT, 9, 0, 0, 1'b1);
      check_lit("t5_swapped", int'(frame_buffer[0][0]), 7);
      check_lit("t5_ready", int'(cmd_ready), 1);
      check_lit("t5_pending_clear", int'(commit_pending), 0);
      check_lit("t5_cursor_col", int'(cursor_col), 1);
      idle(1);

      // Reset during CLEAR and during WAIT_FRAME.
      step(1'b1, OP_CLEAR, 0, 0, 0, 1'b0);
      idle(6);
      do_reset();
      check_lit("t6_clear_reset_fb", fb_sum(), 0);
      check_lit("t6_clear_reset_col", int'(cursor_col), 0);
      check_lit("t6_clear_reset_ready", int'(cmd_ready), 1);
      step(1'b1, OP_PUT, 3, 0, 0, 1'b0);
      step(1'b1, OP_PUT, 5, 0, 0, 1'b0);
      step(1'b1, OP_COMMIT, 0, 0, 0, 1'b0);
      idle(4);
      do_reset();
      check_lit("t6_wait_reset_pending", int'(commit_pending), 0);
      check_lit("t6_wait_reset_ready", int'(cmd_ready), 1);
      check_lit("t6_wait_reset_col", int'(cursor_col), 0);
      idle(2);
      step(1'b0, OP_PUT, 0, 0, 0, 1'b1);
      idle(1);
      check_lit("t6_no_swap_after_reset", fb_sum(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/text_buffer_writer.md
# text_buffer_writer

Command-driven writer for the 10×2 symbol frame buffer that the VGA glyph renderer reads. Software-facing logic sends PUT/MOVE/CLEAR/COMMIT commands over a valid/ready handshake. These edit a private back buffer. The back buffer is copied to the displayed front buffer only on a frame-start pulse from the VGA timing logic, so the display never shows a half-updated frame. It is the producer for the renderer's `frame_buffer [x][y]` input.

## Interface
Parameters:
- COLS, 10, columns (x index)
- ROWS, 2, rows (y index)
- CODE_W, 6, symbol code width; code 0 = blank

Ports:
- clk50  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 PUT, 01 MOVE, 10 CLEAR, 11 COMMIT
- cmd_data  in  CODE_W  symbol code (PUT only)
- cmd_col  in  4  target column (MOVE only)
- cmd_row  in  1  target row (MOVE only)
- frame_start  in  1  one-cycle pulse at end of field, from display timing
- frame_buffer  out  [COLS-1:0][ROWS-1:0] × CODE_W  front buffer, indexed [x][y]
- cursor_col  out  4  current write column
- cursor_row  out  1  current write row
- commit_pending  out  1  a COMMIT is waiting for frame_start

## Operation
- A command is accepted on a clock edge where cmd_valid && cmd_ready. Inputs are ignored otherwise.
- States are IDLE, CLEAR and WAIT_FRAME. cmd_ready = (state == IDLE), decoded from the state register only.
- PUT: back[cursor_col][cursor_row] ← cmd_data. The cursor then advances:
  - col+1 normally;
  - at col COLS-1, col → 0 and row+1;
  - at (COLS-1, ROWS-1), wraps to (0,0).
- PUT with code 0 is legal and blanks the cell.
- MOVE: cursor ← (cmd_col, cmd_row) when cmd_col < COLS. Otherwise the command is accepted and the cursor is unchanged.
- CLEAR: go to CLEAR and sweep cells in linear order row*COLS+col, 0 → COLS*ROWS-1. One cell is written to 0 per cycle. At the end of the sweep the cursor goes to (0,0) and the state returns to IDLE. The front buffer is untouched.
- COMMIT: set commit_pending and go to WAIT_FRAME. On the first frame_start seen in WAIT_FRAME:
  - front ← back, whole array in one cycle;
  - commit_pending clears;
  - state returns to IDLE.
- frame_start is ignored in IDLE and CLEAR. The front buffer holds its value.
- The back buffer is never modified in WAIT_FRAME.

## Timing
- Reset (synchronous) puts every output in a known state:
  - state IDLE, cmd_ready 1;
  - cursor (0,0), commit_pending 0;
  - front and back buffers all 0, so frame_buffer = 0.
- Reset asserted mid-CLEAR or mid-WAIT_FRAME aborts the operation, with no swap.
- PUT and MOVE take effect at the accepting edge. cmd_ready stays high, giving one command per cycle of throughput.
- CLEAR accepted at edge N:
  - cells are zeroed at edges N+1 … N+COLS*ROWS (20 with the defaults);
  - cmd_ready is low during those cycles and high again after edge N+20.
- COMMIT accepted at edge N: cmd_ready and commit_pending are both driven from the state register, so cmd_ready is low and commit_pending high from cycle N+1.
- frame_start high in the same cycle that a COMMIT is accepted does not swap. The swap waits for the next frame_start.
- frame_buffer changes only at the edge sampling frame_start in WAIT_FRAME. At that edge cmd_ready rises and commit_pending falls.
- All outputs come directly from registers. There is no combinational path from cmd_* to any output.

## Structure
- Package text_buffer_pkg holds:
  - COLS, ROWS, CODE_W defaults;
  - op enum: OP_PUT, OP_MOVE, OP_CLEAR, OP_COMMIT;
  - state enum: S_IDLE, S_CLEAR, S_WAIT_FRAME.
- Sub-module cell_cursor is a col/row counter with load, advance and wrap at COLS/ROWS, plus a last-cell flag. It is instantiated twice: once as the write cursor and once as the CLEAR sweep index.

## Test plan
- Reset, then 10 PUTs of codes 1..10 and COMMIT, with frame_start 50 cycles later:
  - frame_buffer[0..9][0] = 1..10 and row 1 = 0 only after the frame_start edge;
  - cursor ends at (0,1).
- 20 PUTs followed by 1 PUT (code 6), then COMMIT → cell [0][0] = 6, cursor at (1,0).
- MOVE (3,1), PUT 4 → back[3][1] = 4, cursor (4,1). Then MOVE (12,0) → accepted, cursor stays (4,1).
- Fill all cells, commit, then CLEAR:
  - cmd_ready is low exactly 20 cycles;
  - frame_buffer stays full until a later COMMIT+frame_start, after which it is all 0.
- COMMIT accepted in the same cycle as frame_start → no swap. Swap occurs at the next frame_start, and cmd_valid held high stays blocked in between.
- Assert reset during CLEAR (cycle 7) and during WAIT_FRAME → all buffers 0, cursor (0,0), cmd_ready 1 on the cycle after reset.
